// File: rtl/adc_sequencer_if.sv
// adc_sequencer_if: groups the sequencer's run control, SPI pins, FIFO strobes and status.
// Latency: none, wires only.
// Backpressure: none carried here; the sequencer watches fifo_rd to mirror FIFO occupancy.
//
// master : the sequencer (drives SPI pins, FIFO write side and status)
// slave  : the environment (drives enable, adc_miso and the consumer read strobe)
interface adc_sequencer_if;
   logic        enable;
   logic        adc_csn;
   logic        adc_sclk;
   logic        adc_mosi;
   logic        adc_miso;
   logic        fifo_wr;
   logic [15:0] fifo_data;
   logic        fifo_rd;
   logic [3:0]  level;
   logic [7:0]  overrun;
   logic        busy;

   modport master (
      input  enable, adc_miso, fifo_rd,
      output adc_csn, adc_sclk, adc_mosi, fifo_wr, fifo_data, level, overrun, busy
   );

   modport slave (
      output enable, adc_miso, fifo_rd,
      input  adc_csn, adc_sclk, adc_mosi, fifo_wr, fifo_data, level, overrun, busy
   );
endinterface

// File: rtl/adc_sequencer.sv
// adc_sequencer: period-timed SPI ADC sampler; pushes {channel, sample} words into an 8-entry ring FIFO.
// Latency: tick -> adc_csn low 1 cycle; a frame is 34*SCLK_DIV+1 cycles from START to end of PUSH.
// Backpressure: FIFO occupancy is mirrored; with ADC_SEQ_OVERRUN_EN a full FIFO drops and counts samples.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   bus (master modport)  enable in; adc_csn/adc_sclk/adc_mosi out, adc_miso in (SPI mode 0);
//                         fifo_wr/fifo_data out, fifo_rd in; level/overrun/busy status out
// Optional feature macro: ADC_SEQ_OVERRUN_EN (drop samples at level 7 and count them in overrun).
//   Undefined: every PUSH writes, level saturates at 7 and overrun reads 0.
module adc_sequencer #(
   parameter int PERIOD   = 1000,  // clk cycles between ticks, >= 2
   parameter int SCLK_DIV = 2,     // clk cycles per SCLK half-period, >= 1
   parameter int CHANNELS = 8      // channels in the rotation, 1..8
) (
   input  logic            clk,
   input  logic            reset,
   adc_sequencer_if.master bus
);

   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'(PERIOD - 1);
   localparam logic [DW-1:0] D_LAST  = DW'(SCLK_DIV - 1);
   localparam logic [2:0]    CH_LAST = 3'(CHANNELS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SHIFT = 3'd2,
      STOP  = 3'd3,
      PUSH  = 3'd4
   } state_t;

   state_t state, state_nx;

   // period timer and the single-entry tick latch
   logic [TW-1:0] timer;
   logic          tick;
   logic          pending;
   logic          take;

   // SPI sequencing
   logic [DW-1:0] div_cnt;
   logic          div_last;
   logic          sclk_hi;     // current SCLK half-period is the high one
   logic [3:0]    bit_cnt;     // bit being transferred, 0 = MSB
   logic [15:0]   cmd;
   // Only the last 12 bits shifted in are ever used, so the top 4 bits of the
   // 16-bit receive word simply fall off the end of this register.
   logic [11:0]   rx_sh;
   logic [2:0]    channel;

   // occupancy mirror and drop accounting
   logic [3:0]    level;
   logic [7:0]    overrun;
   logic          push_ok;

   // decoded outputs
   logic          csn_c;
   logic          sclk_c;
   logic          mosi_c;
   logic          wr_c;
   logic [15:0]   data_c;
   logic          busy_c;

   // ------------------------------------------------------------------
   // Timer: free-runs 0..PERIOD-1 while enabled. A tick seen in IDLE starts
   // the frame directly so chip select falls one cycle after the tick; a tick
   // seen elsewhere is latched in pending. Ticks arriving while pending is
   // already set (including the cycle it is consumed) are lost.
   // ------------------------------------------------------------------
   assign tick = bus.enable && (timer == T_LAST);
   assign take = bus.enable && (state == IDLE) && (pending || tick);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer   <= '0;
         pending <= 1'b0;
      end else if (!bus.enable) begin
         timer   <= '0;
         pending <= 1'b0;
      end else begin
         timer   <= tick ? '0 : timer + TW'(1);
         pending <= take ? 1'b0 : (pending | tick);
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   assign div_last = (div_cnt == D_LAST);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (take) state_nx = START;
         START:   if (div_last) state_nx = SHIFT;
         SHIFT:   if (div_last && sclk_hi && (bit_cnt == 4'd15)) state_nx = STOP;
         STOP:    if (div_last) state_nx = PUSH;
         PUSH:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs. All SPI pins are decoded from registered state, so an
   // asynchronous reset returns them to idle levels at once and can never
   // leave a write strobe behind.
   // ------------------------------------------------------------------
   assign cmd = {2'b11, channel, 11'b0};

`ifdef ADC_SEQ_OVERRUN_EN
   // Decision uses the registered level: a read in the same cycle does not
   // make room for this sample.
   assign push_ok = (level != 4'd7);
`else
   assign push_ok = 1'b1;
`endif

   always_comb begin
      csn_c  = 1'b1;
      sclk_c = 1'b0;
      mosi_c = 1'b0;
      wr_c   = 1'b0;
      data_c = '0;
      busy_c = (state != IDLE);
      unique case (state)
         START: csn_c = 1'b0;
         SHIFT: begin
            csn_c  = 1'b0;
            sclk_c = sclk_hi;
            // bit_cnt only moves at the end of a high phase, so mosi changes
            // exactly at the start of each low phase
            mosi_c = cmd[4'd15 - bit_cnt];
         end
         PUSH: begin
            wr_c = push_ok;
            if (push_ok) begin
               data_c = {1'b0, channel, rx_sh};
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // SPI datapath: half-period divider, bit counter, receive shifter and
   // channel rotation.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         sclk_hi <= 1'b0;
         bit_cnt <= '0;
         rx_sh   <= '0;
         channel <= '0;
      end else begin
         if ((state == IDLE) || (state == PUSH) || div_last) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end

         if ((state == SHIFT) && div_last) begin
            sclk_hi <= !sclk_hi;
            if (sclk_hi) begin
               bit_cnt <= bit_cnt + 4'd1;   // wraps back to 0 after bit 15
            end
         end

         // first cycle of the high phase is the cycle SCLK rises
         if ((state == SHIFT) && sclk_hi && (div_cnt == '0)) begin
            rx_sh <= {rx_sh[10:0], bus.adc_miso};
         end

         // rotate even when the sample was dropped
         if (state == PUSH) begin
            channel <= (channel == CH_LAST) ? 3'd0 : channel + 3'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Occupancy mirror. Capacity is 7 because a full 8-entry ring would look
   // empty; the saturation only matters when drops are not enabled.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= '0;
      end else if (wr_c && !bus.fifo_rd) begin
         if (level != 4'd7) begin
            level <= level + 4'd1;
         end
      end else if (!wr_c && bus.fifo_rd && (level != 4'd0)) begin
         level <= level - 4'd1;
      end
   end

`ifdef ADC_SEQ_OVERRUN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= '0;
      end else if ((state == PUSH) && !push_ok && (overrun != 8'hFF)) begin
         overrun <= overrun + 8'd1;
      end
   end
`else
   assign overrun = '0;
`endif

   assign bus.adc_csn   = csn_c;
   assign bus.adc_sclk  = sclk_c;
   assign bus.adc_mosi  = mosi_c;
   assign bus.fifo_wr   = wr_c;
   assign bus.fifo_data = data_c;
   assign bus.level     = level;
   assign bus.overrun   = overrun;
   assign bus.busy      = busy_c;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: self-checking bench for adc_sequencer.
// Instance A (PERIOD=100, SCLK_DIV=2, CHANNELS=3) runs table frames, random frames, fill-up and mid-frame reset.
// Instance B (PERIOD=10, SCLK_DIV=2, CHANNELS=8) checks back-to-back frame spacing.
module tb_adc_sequencer;

   localparam int PA  = 100;
   localparam int SD  = 2;
   localparam int CHA = 3;
   localparam int PB  = 10;

`ifdef ADC_SEQ_OVERRUN_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 clk = ~clk;

   adc_sequencer_if ia();
   adc_sequencer_if ib();

   adc_sequencer #(.PERIOD(PA), .SCLK_DIV(SD), .CHANNELS(CHA)) u_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ia)
   );

   adc_sequencer #(.PERIOD(PB), .SCLK_DIV(SD), .CHANNELS(8)) u_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ib)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state for instance A
   int m_level;
   int m_ovr;
   int m_ch;

   typedef struct {
      logic [15:0] reply;
      int          rd_mode;   // 0 none, 1 read in PUSH cycle, 2 read mid-frame
      logic [15:0] exp_data;
      logic [15:0] exp_cmd;
      int          exp_level;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of instance A seen from a negedge: compare the registered level
   // and the write strobe with the model, drive fifo_rd for the coming edge,
   // then advance the model by the occupancy rules.
   task automatic step(input logic rd, input logic push);
      logic w;
      w = push && !(OVR && (m_level == 7));
      chk("level", ia.level, m_level);
      chk("fifo_wr", ia.fifo_wr, w);
      ia.fifo_rd = rd;
      if (push && !w && m_ovr < 255) m_ovr++;
      if (w && !rd) m_level = (m_level < 7) ? m_level + 1 : 7;
      else if (rd && !w && m_level > 0) m_level--;
      @(negedge clk);
   endtask

   // Plays the ADC for one frame of instance A and checks its shape.
   task automatic run_frame(input logic [15:0] reply, input int rd_mode, input bit first,
                            output logic [15:0] cmd, output int wr_n, output logic [15:0] wr_dat);
      int   t;
      int   low_cyc;
      int   rises;
      logic prev;
      logic rd;
      logic exp_w;
      t = 0; low_cyc = 0; rises = 0; prev = 1'b0;
      cmd = '0; wr_n = 0; wr_dat = '0;
      while (ia.adc_csn !== 1'b0 && t < 2 * PA) begin
         step(1'b0, 1'b0);
         t++;
      end
      chk("tick_to_csn", t, first ? PA : PA - 34 * SD - 2);
      if (ia.adc_csn !== 1'b0) return;
      while (ia.adc_csn === 1'b0 && low_cyc < 40 * SD) begin
         chk("busy_in_frame", ia.busy, 1'b1);
         if (ia.adc_sclk && !prev) begin
            rises++;
            cmd = {cmd[14:0], ia.adc_mosi};
         end
         prev = ia.adc_sclk;
         if (!ia.adc_sclk && rises < 16) ia.adc_miso = reply[15 - rises];
         rd = (rd_mode == 2 && low_cyc == 10) || (rd_mode == 3 && $urandom_range(3) == 0);
         low_cyc++;
         step(rd, 1'b0);
      end
      chk("csn_low_cycles", low_cyc, 33 * SD);
      chk("sclk_pulses", rises, 16);
      chk("mosi_cmd", cmd, {2'b11, 3'(m_ch), 11'b0});
      // STOP occupies k = 0..SD-1, PUSH is k = SD
      for (int k = 0; k < SD + 2; k++) begin
         exp_w = (k == SD) && !(OVR && (m_level == 7));
         if (ia.fifo_wr === 1'b1) begin
            wr_n++;
            wr_dat = ia.fifo_data;
         end
         if (exp_w) chk("fifo_data", ia.fifo_data, {1'b0, 3'(m_ch), reply[11:0]});
         rd = (rd_mode == 1 && k == SD) || (rd_mode == 3 && $urandom_range(3) == 0);
         step(rd, k == SD);
      end
      chk("overrun", ia.overrun, m_ovr);
      m_ch = (m_ch + 1) % CHA;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cmd;
      logic [15:0] wd;
      int wn, wsum, t, rs, cnt, bcnt, idle, blen, wrs;
      logic prev;

      tbl[0] = '{16'hFA5C, 2, 16'h0A5C, 16'hC000, 1};
      tbl[1] = '{16'h1234, 0, 16'h1234, 16'hC800, 2};
      tbl[2] = '{16'hE0F1, 0, 16'h20F1, 16'hD000, 3};
      tbl[3] = '{16'h0ABC, 1, 16'h0ABC, 16'hC000, 3};
      tbl[4] = '{16'h5555, 2, 16'h1555, 16'hC800, 3};
      tbl[5] = '{16'hFFFF, 0, 16'h2FFF, 16'hD000, 4};

      // reset with busy-looking inputs
      rst_a = 1'b1; rst_b = 1'b1;
      ia.enable = 1'b1; ia.adc_miso = 1'b1; ia.fifo_rd = 1'b1;
      ib.enable = 1'b0; ib.adc_miso = 1'b0; ib.fifo_rd = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_csn", ia.adc_csn, 1'b1);
      chk("rst_sclk", ia.adc_sclk, 1'b0);
      chk("rst_mosi", ia.adc_mosi, 1'b0);
      chk("rst_fifo_wr", ia.fifo_wr, 1'b0);
      chk("rst_fifo_data", ia.fifo_data, 16'h0000);
      chk("rst_level", ia.level, 4'd0);
      chk("rst_overrun", ia.overrun, 8'd0);
      chk("rst_busy", ia.busy, 1'b0);

      rst_b = 1'b0; ib.enable = 1'b1;
      ia.fifo_rd = 1'b0; ia.adc_miso = 1'b0;
      m_level = 0; m_ovr = 0; m_ch = 0;
      rst_a = 1'b0;

      // table-driven frames
      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i].reply, tbl[i].rd_mode, i == 0, cmd, wn, wd);
         chk("tbl_wr_count", wn, 1);
         chk("tbl_data", wd, tbl[i].exp_data);
         chk("tbl_cmd", cmd, tbl[i].exp_cmd);
         chk("tbl_level", ia.level, tbl[i].exp_level);
      end

      // random replies and random consumer reads against the model
      for (int i = 0; i < 12; i++) begin
         run_frame(16'($urandom), 3, 1'b0, cmd, wn, wd);
      end

      // fill-up: 9 frames without reads from a fresh reset
      rst_a = 1'b1; ia.fifo_rd = 1'b0;
      @(negedge clk);
      m_level = 0; m_ovr = 0; m_ch = 0;
      rst_a = 1'b0;
      wsum = 0;
      for (int i = 0; i < 9; i++) begin
         run_frame(16'(32'h0111 * (i + 1)), 0, i == 0, cmd, wn, wd);
         wsum += wn;
      end
      chk("fill_level", ia.level, 4'd7);
      chk("fill_overrun", ia.overrun, OVR ? 8'd2 : 8'd0);
      chk("fill_wr_pulses", wsum, OVR ? 7 : 9);

      // reset in the middle of the shift phase
      t = 0;
      while (ia.adc_csn !== 1'b0 && t < 2 * PA) begin @(negedge clk); t++; end
      rs = 0; prev = 1'b0;
      while (rs < 8 && t < 4 * PA) begin
         if (ia.adc_sclk && !prev) rs++;
         prev = ia.adc_sclk;
         @(negedge clk);
         t++;
      end
      rst_a = 1'b1;
      #1;
      chk("midrst_csn", ia.adc_csn, 1'b1);
      chk("midrst_sclk", ia.adc_sclk, 1'b0);
      chk("midrst_busy", ia.busy, 1'b0);
      chk("midrst_level", ia.level, 4'd0);
      chk("midrst_fifo_wr", ia.fifo_wr, 1'b0);
      @(negedge clk);
      rst_a = 1'b0;
      cnt = 0; bcnt = 0;
      repeat (PA - 2) begin
         @(negedge clk);
         cnt += int'(ia.fifo_wr);
         bcnt += int'(ia.busy);
      end
      chk("midrst_no_wr", cnt, 0);
      chk("midrst_no_busy", bcnt, 0);

      // instance B: frames back to back, one IDLE cycle between PUSH and START
      t = 0;
      while (ib.busy !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      while (ib.busy === 1'b1 && t < 500) begin @(negedge clk); t++; end
      for (int f = 0; f < 4; f++) begin
         idle = 0; blen = 0; wrs = 0;
         while (ib.busy !== 1'b1 && idle < 100) begin @(negedge clk); idle++; end
         while (ib.busy === 1'b1 && blen < 200) begin
            wrs += int'(ib.fifo_wr);
            blen++;
            @(negedge clk);
         end
         chk("b2b_idle", idle, 1);
         chk("b2b_frame_len", blen, 34 * SD + 1);
         chk("b2b_wr_per_frame", wrs, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
